cascade_counter_ctl: RTL and testbench

- Parametrised successor to the team's fixed three-stage, 4-bit cascaded counter controllers.
- NUM_STAGES counter stages of STAGE_W bits are chained by ripple-enable. Each stage advances only when every lower stage is at its terminal value.
- Adds up/down mode, parallel load, selectable stop-or-wrap at terminal count, a valid/ready terminal-count event handshake, and a sticky overflow flag.
- Sits as a timing/sequencing leaf next to the existing sequential benchmark blocks and is driven by a simple control master.

---
 rtl/cascade_counter_pkg.sv | 17 +
 rtl/counter_stage.sv | 48 ++++
 rtl/cascade_counter_ctl.sv | 135 +++++++++++++
 tb/tb_cascade_counter_ctl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cascade_counter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cascade_counter_pkg : shared encodings for the cascaded counter controller
// Rev 1.0
// ---------------------------------------------------------------------------
package cascade_counter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    function automatic int total_width(input int num_stages, input int stage_w);
        return num_stages * stage_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_stage : one up/down stage of the cascade, reports its terminal value
// Rev 1.0
// ---------------------------------------------------------------------------
module counter_stage #(
    parameter int STAGE_W = 4
) (
    input  logic               CK,
    input  logic               RST,
    input  logic               clr,
    input  logic               load,
    input  logic [STAGE_W-1:0] load_val,
    input  logic               cin,
    input  logic               mode,
    output logic [STAGE_W-1:0] q,
    output logic               at_term
);

    localparam logic [STAGE_W-1:0] c_ONE = STAGE_W'(1);

    logic [STAGE_W-1:0] q_q;
    logic [STAGE_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = load_val;
        end else if (cin) begin
            q_d = mode ? (q_q - c_ONE) : (q_q + c_ONE);
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q       = q_q;
    assign at_term = mode ? (q_q == '0) : (q_q == '1);

endmodule
`default_nettype wire

// File: rtl/cascade_counter_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cascade_counter_ctl : ripple-enabled stage cascade with TC handshake and OVF
// Rev 1.0
// ---------------------------------------------------------------------------
module cascade_counter_ctl
    import cascade_counter_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int STAGE_W    = 4,
    parameter bit STOP_ON_TC = 1'b0
) (
    input  logic                            CK,
    input  logic                            RST,
    input  logic                            CLR,
    input  logic                            EN,
    input  logic                            MODE,
    input  logic                            LOAD,
    input  logic [NUM_STAGES*STAGE_W-1:0]   LOAD_VAL,
    input  logic                            TC_READY,
    output logic [NUM_STAGES*STAGE_W-1:0]   COUNT,
    output logic [NUM_STAGES-1:0]           CARRY,
    output logic                            TC_VALID,
    output logic                            OVF,
    output logic [1:0]                      STATE
);

    localparam int c_TOTAL_W = total_width(NUM_STAGES, STAGE_W);

    logic [1:0]            state_q, state_d;
    logic                  tc_valid_q, tc_valid_d;
    logic                  ovf_q, ovf_d;

    logic [NUM_STAGES-1:0] w_at_term;
    logic [NUM_STAGES-1:0] w_carry;
    logic [NUM_STAGES-1:0] w_adv;
    logic [c_TOTAL_W-1:0]  w_count;
    logic                  w_all_term;
    logic                  w_cand;
    logic                  w_tc_event;
    logic                  w_freeze;
    logic                  w_hs;
    logic                  w_hold_step;

    assign w_all_term  = &w_at_term;
    assign w_cand      = (state_q == ST_RUN) & EN & ~LOAD & ~CLR;
    assign w_tc_event  = w_cand & w_all_term;
    assign w_freeze    = STOP_ON_TC & w_tc_event;
    assign w_hs        = tc_valid_q & TC_READY;
    assign w_hold_step = (state_q == ST_HOLD) & w_hs & ~LOAD & ~CLR;

    // The release from HOLD reuses the ripple chain so it moves exactly one
    // position in the current direction, but it is not reported on CARRY.
    always_comb begin
        w_carry    = '0;
        w_adv      = '0;
        w_carry[0] = w_cand & ~w_freeze;
        w_adv[0]   = w_carry[0] | w_hold_step;
        for (int i = 1; i < NUM_STAGES; i++) begin
            w_carry[i] = w_carry[i-1] & w_at_term[i-1];
            w_adv[i]   = w_adv[i-1]   & w_at_term[i-1];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            counter_stage #(
                .STAGE_W (STAGE_W)
            ) u_stage (
                .CK       (CK),
                .RST      (RST),
                .clr      (CLR),
                .load     (LOAD),
                .load_val (LOAD_VAL[gi*STAGE_W +: STAGE_W]),
                .cin      (w_adv[gi]),
                .mode     (MODE),
                .q        (w_count[gi*STAGE_W +: STAGE_W]),
                .at_term  (w_at_term[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        tc_valid_d = tc_valid_q;
        ovf_d      = ovf_q;
        if (CLR) begin
            state_d    = ST_IDLE;
            tc_valid_d = 1'b0;
            ovf_d      = 1'b0;
        end else if (!LOAD) begin
            case (state_q)
                ST_IDLE: if (EN) state_d = ST_RUN;
                ST_RUN: begin
                    if (!EN) begin
                        state_d = ST_IDLE;
                    end else if (w_freeze) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: if (w_hs) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
            // A new event outranks the handshake so a back-to-back event is kept.
            if (w_tc_event) begin
                tc_valid_d = 1'b1;
            end else if (w_hs) begin
                tc_valid_d = 1'b0;
            end
            if (w_tc_event & tc_valid_q & ~TC_READY) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            tc_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tc_valid_q <= tc_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign COUNT    = w_count;
    assign CARRY    = w_carry;
    assign TC_VALID = tc_valid_q;
    assign OVF      = ovf_q;
    assign STATE    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cascade_counter_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cascade_counter_ctl : vectors, corner sequences and random run vs model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cascade_counter_ctl;

    logic        CK = 1'b0;
    logic        RST, CLR, EN, MODE, LOAD, TC_READY;
    logic [11:0] LOAD_VAL;

    logic [11:0] cnt0, cnt1;
    logic [7:0]  cnt2;
    logic [2:0]  carry0, carry1;
    logic [0:0]  carry2;
    logic        tcv0, tcv1, tcv2, ovf0, ovf1, ovf2;
    logic [1:0]  st0, st1, st2;

    always #5 CK = ~CK;

    cascade_counter_ctl #(.NUM_STAGES(3), .STAGE_W(4), .STOP_ON_TC(1'b0)) dut0 (
        .CK(CK), .RST(RST), .CLR(CLR), .EN(EN), .MODE(MODE), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL), .TC_READY(TC_READY), .COUNT(cnt0), .CARRY(carry0),
        .TC_VALID(tcv0), .OVF(ovf0), .STATE(st0));

    cascade_counter_ctl #(.NUM_STAGES(3), .STAGE_W(4), .STOP_ON_TC(1'b1)) dut1 (
        .CK(CK), .RST(RST), .CLR(CLR), .EN(EN), .MODE(MODE), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL), .TC_READY(TC_READY), .COUNT(cnt1), .CARRY(carry1),
        .TC_VALID(tcv1), .OVF(ovf1), .STATE(st1));

    cascade_counter_ctl #(.NUM_STAGES(1), .STAGE_W(8), .STOP_ON_TC(1'b0)) dut2 (
        .CK(CK), .RST(RST), .CLR(CLR), .EN(EN), .MODE(MODE), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL[7:0]), .TC_READY(TC_READY), .COUNT(cnt2), .CARRY(carry2),
        .TC_VALID(tcv2), .OVF(ovf2), .STATE(st2));

    typedef struct {
        int unsigned cnt;
        int          st;
        bit          tcv;
        bit          ovf;
    } mdl_t;

    typedef struct {
        bit          clr, en, mode, load, rdy;
        logic [11:0] lv;
        logic [11:0] ecnt;
        logic [1:0]  est;
        bit          etcv, eovf;
    } vec_t;

    mdl_t m [3];
    int   nst [3] = '{3, 3, 1};
    int   wst [3] = '{4, 4, 8};
    bit   stp [3] = '{1'b0, 1'b1, 1'b0};
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-counter arithmetic: the cascade behaves as one counter of n*w bits.
    function automatic void model(input int n, input int w, input bit stop, input mdl_t cur,
                                  output mdl_t nxt, output int unsigned carry);
        int unsigned max  = (32'd1 << (n * w)) - 1;
        int unsigned term = MODE ? 0 : max;
        bit run_ok = (cur.st == 1) && EN && !LOAD && !CLR;
        bit tc     = run_ok && (cur.cnt == term);
        bit step   = run_ok && !(stop && tc);
        bit hs     = cur.tcv && TC_READY;
        carry = 0;
        for (int i = 0; i < n; i++) begin
            int unsigned span = 32'd1 << (i * w);
            if (step && ((cur.cnt % span) == (MODE ? 0 : span - 1))) carry |= (32'd1 << i);
        end
        nxt = cur;
        if (CLR) begin
            nxt = '{0, 0, 1'b0, 1'b0};
        end else if (LOAD) begin
            nxt.cnt = LOAD_VAL & max;
        end else begin
            if (step || (cur.st == 2 && hs))
                nxt.cnt = MODE ? ((cur.cnt + max) & max) : ((cur.cnt + 1) & max);
            case (cur.st)
                0: if (EN) nxt.st = 1;
                1: if (!EN) nxt.st = 0; else if (stop && tc) nxt.st = 2;
                default: if (hs) nxt.st = 0;
            endcase
            if (tc) nxt.tcv = 1'b1;
            else if (hs) nxt.tcv = 1'b0;
            if (tc && cur.tcv && !TC_READY) nxt.ovf = 1'b1;
        end
    endfunction

    function automatic int unsigned dut_cnt(input int k);
        return (k == 0) ? {20'd0, cnt0} : (k == 1) ? {20'd0, cnt1} : {24'd0, cnt2};
    endfunction
    function automatic int unsigned dut_carry(input int k);
        return (k == 0) ? {29'd0, carry0} : (k == 1) ? {29'd0, carry1} : {31'd0, carry2};
    endfunction
    function automatic int unsigned dut_st(input int k);
        return (k == 0) ? {30'd0, st0} : (k == 1) ? {30'd0, st1} : {30'd0, st2};
    endfunction
    function automatic int unsigned dut_tcv(input int k);
        return (k == 0) ? {31'd0, tcv0} : (k == 1) ? {31'd0, tcv1} : {31'd0, tcv2};
    endfunction
    function automatic int unsigned dut_ovf(input int k);
        return (k == 0) ? {31'd0, ovf0} : (k == 1) ? {31'd0, ovf1} : {31'd0, ovf2};
    endfunction

    task automatic check_regs();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d_count", k), dut_cnt(k), m[k].cnt);
            chk($sformatf("d%0d_state", k), dut_st(k), m[k].st);
            chk($sformatf("d%0d_tc_valid", k), dut_tcv(k), {31'd0, m[k].tcv});
            chk($sformatf("d%0d_ovf", k), dut_ovf(k), {31'd0, m[k].ovf});
        end
    endtask

    task automatic reset_models();
        for (int k = 0; k < 3; k++) m[k] = '{0, 0, 1'b0, 1'b0};
    endtask

    // Caller drives inputs just after an edge; CARRY is checked mid-cycle.
    task automatic cycle();
        mdl_t        nx [3];
        int unsigned cy;
        #1;
        for (int k = 0; k < 3; k++) begin
            model(nst[k], wst[k], stp[k], m[k], nx[k], cy);
            chk($sformatf("d%0d_carry", k), dut_carry(k), cy);
        end
        @(posedge CK);
        #1;
        for (int k = 0; k < 3; k++) m[k] = nx[k];
        check_regs();
    endtask

    task automatic drive(input bit clr, input bit en, input bit mode, input bit load,
                         input bit rdy, input logic [11:0] lv);
        CLR = clr; EN = en; MODE = mode; LOAD = load; TC_READY = rdy; LOAD_VAL = lv;
    endtask

    vec_t tbl [20];

    initial begin
        int pulses, run, maxrun;
        logic [11:0] near [5];

        tbl[0]  = '{0,1,0,0,0, 12'h000, 12'h000, 2'd1, 0, 0};
        tbl[1]  = '{0,1,0,0,0, 12'h000, 12'h001, 2'd1, 0, 0};
        tbl[2]  = '{0,1,0,1,0, 12'h00F, 12'h00F, 2'd1, 0, 0};
        tbl[3]  = '{0,1,0,0,0, 12'h000, 12'h010, 2'd1, 0, 0};
        tbl[4]  = '{0,1,0,1,0, 12'h0FF, 12'h0FF, 2'd1, 0, 0};
        tbl[5]  = '{0,1,0,0,0, 12'h000, 12'h100, 2'd1, 0, 0};
        tbl[6]  = '{0,1,0,1,0, 12'hFFE, 12'hFFE, 2'd1, 0, 0};
        tbl[7]  = '{0,1,0,0,0, 12'h000, 12'hFFF, 2'd1, 0, 0};
        tbl[8]  = '{0,1,0,0,0, 12'h000, 12'h000, 2'd1, 1, 0};
        tbl[9]  = '{0,1,0,0,0, 12'h000, 12'h001, 2'd1, 1, 0};
        tbl[10] = '{0,1,0,1,0, 12'hFFF, 12'hFFF, 2'd1, 1, 0};
        tbl[11] = '{0,1,0,0,0, 12'h000, 12'h000, 2'd1, 1, 1};
        tbl[12] = '{0,0,0,0,0, 12'h000, 12'h000, 2'd0, 1, 1};
        tbl[13] = '{0,0,0,0,1, 12'h000, 12'h000, 2'd0, 0, 1};
        tbl[14] = '{1,0,0,0,0, 12'h000, 12'h000, 2'd0, 0, 0};
        tbl[15] = '{0,1,1,0,0, 12'h000, 12'h000, 2'd1, 0, 0};
        tbl[16] = '{0,1,1,0,0, 12'h000, 12'hFFF, 2'd1, 1, 0};
        tbl[17] = '{0,1,1,0,1, 12'h000, 12'hFFE, 2'd1, 0, 0};
        tbl[18] = '{1,1,0,1,0, 12'hFFF, 12'h000, 2'd0, 0, 0};
        tbl[19] = '{0,1,0,1,0, 12'h5A3, 12'h5A3, 2'd0, 0, 0};

        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 12'h000);
        @(posedge CK);
        #1;
        RST = 1'b0;
        reset_models();
        check_regs();

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].clr, tbl[i].en, tbl[i].mode, tbl[i].load, tbl[i].rdy, tbl[i].lv);
            cycle();
            chk($sformatf("tbl%0d_count", i), {20'd0, cnt0}, {20'd0, tbl[i].ecnt});
            chk($sformatf("tbl%0d_state", i), {30'd0, st0}, {30'd0, tbl[i].est});
            chk($sformatf("tbl%0d_tc_valid", i), {31'd0, tcv0}, {31'd0, tbl[i].etcv});
            chk($sformatf("tbl%0d_ovf", i), {31'd0, ovf0}, {31'd0, tbl[i].eovf});
        end

        // Asynchronous reset seen before any clock edge.
        drive(0, 0, 0, 0, 0, 12'h000);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_count", {20'd0, cnt0}, 0);
        chk("async_rst_state", {30'd0, st0}, 0);
        chk("async_rst_tc_valid", {31'd0, tcv0}, 0);
        chk("async_rst_ovf", {31'd0, ovf0}, 0);
        reset_models();
        #1;
        RST = 1'b0;
        cycle();

        // Stop-on-terminal freeze and handshake release (dut1).
        drive(0, 1, 0, 0, 0, 12'h000); cycle();
        drive(0, 1, 0, 1, 0, 12'hFFD); cycle();
        drive(0, 1, 0, 0, 0, 12'h000);
        for (int i = 0; i < 5; i++) cycle();
        chk("hold_count", {20'd0, cnt1}, 12'hFFF);
        chk("hold_state", {30'd0, st1}, 2);
        chk("hold_tc_valid", {31'd0, tcv1}, 1);
        drive(0, 1, 0, 0, 1, 12'h000); cycle();
        chk("release_count", {20'd0, cnt1}, 12'h000);
        chk("release_state", {30'd0, st1}, 0);
        chk("release_tc_valid", {31'd0, tcv1}, 0);

        // Down-count wrap twice with no consumer: overflow.
        drive(1, 0, 0, 0, 0, 12'h000); cycle();
        drive(0, 1, 1, 0, 0, 12'h000); cycle();
        drive(0, 1, 1, 1, 0, 12'h001); cycle();
        drive(0, 1, 1, 0, 0, 12'h000);
        for (int i = 0; i < 4098; i++) cycle();
        chk("wrap2_count", {20'd0, cnt0}, 12'hFFF);
        chk("wrap2_tc_valid", {31'd0, tcv0}, 1);
        chk("wrap2_ovf", {31'd0, ovf0}, 1);
        drive(1, 0, 0, 0, 0, 12'h000); cycle();
        chk("clr_ovf", {31'd0, ovf0}, 0);
        chk("clr_count", {20'd0, cnt0}, 0);

        // Single 8-bit stage with consumer always ready (dut2).
        drive(0, 1, 0, 0, 1, 12'h000);
        pulses = 0; run = 0; maxrun = 0;
        for (int i = 0; i < 600; i++) begin
            cycle();
            if (tcv2) begin
                run++;
                if (run == 1) pulses++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        chk("w8_pulses", pulses, 2);
        chk("w8_pulse_len", maxrun, 1);
        chk("w8_ovf", {31'd0, ovf2}, 0);

        // Randomised traffic biased toward terminal-adjacent loads.
        near[0] = 12'hFFF; near[1] = 12'h000; near[2] = 12'hFFE;
        near[3] = 12'h001; near[4] = 12'hEFF;
        for (int i = 0; i < 3000; i++) begin
            CLR      = ($urandom_range(63) == 0);
            LOAD     = ($urandom_range(15) == 0);
            EN       = ($urandom_range(7) != 0);
            TC_READY = ($urandom_range(2) == 0);
            if ($urandom_range(31) == 0) MODE = ~MODE;
            LOAD_VAL = ($urandom_range(1) == 0) ? near[$urandom_range(4)]
                                                : 12'($urandom_range(4095));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
